// File: rtl/score_packer_pkg.sv
// Shared helpers for the classifier output stage: width sizing and lane slicing.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package score_packer_pkg;

  // Ceiling log2, evaluated at elaboration time to size counters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // LSB position of lane k in a packed frame. Lane 0 sits in the LSBs;
  // the argmax stage slices frames with the same helper.
  function automatic int lane_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/score_packer_if.sv
// Score stream in / packed frame out bundle between last layer, packer and argmax.
// Latency: n/a (wiring only).
// Backpressure: none; the score stream is never stalled.
interface score_packer_if #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16
);
  logic [INPUT_WIDTH-1:0]           i_data;
  logic                             i_valid;
  logic                             i_last;
  logic [NUM_INPUT*INPUT_WIDTH-1:0] o_data;
  logic                             o_valid;
  logic                             o_busy;
  logic                             o_err;

  // Producer side: drives scores, observes packed frames.
  modport master (
    output i_data, i_valid, i_last,
    input  o_data, o_valid, o_busy, o_err
  );

  // Packer side.
  modport slave (
    input  i_data, i_valid, i_last,
    output o_data, o_valid, o_busy, o_err
  );
endinterface

// File: rtl/score_packer_gap_timer.sv
// Minimum-spacing timer: loads on an emission, counts down, saturates at zero.
// Latency: zero flag reflects the registered count (load takes effect next cycle).
// Backpressure: none; the owner gates its own emission with the zero flag.
module score_packer_gap_timer #(
  parameter int WIDTH = 4,
  parameter int LOAD  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);
  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(LOAD);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: reload on emission, otherwise decrement and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/score_packer.sv
// Packs numInput serial scores into one frame and pulses it to argmax, spaced by minGap.
// Latency: 1 cycle from the last word when idle; later if held by the gap timer.
// Backpressure: none; one frame can wait in pending, a further completed frame is dropped with o_err.
module score_packer
  import score_packer_pkg::*;
#(
  parameter int numInput   = 10,
  parameter int inputWidth = 16,
  parameter int minGap     = numInput + 1
) (
  input logic           clk,
  input logic           rst,
  score_packer_if.slave bus
);
  localparam int IDX_W = (clog2(numInput) < 1) ? 1 : clog2(numInput);
  localparam int GAP_W = (clog2(minGap + 1) < 1) ? 1 : clog2(minGap + 1);
  localparam int DW    = numInput * inputWidth;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numInput - 1);

  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [DW-1:0]    collect_q,  collect_d;
  logic [DW-1:0]    pend_q,     pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DW-1:0]    o_data_q,   o_data_d;
  logic             o_valid_q,  o_valid_d;
  logic             o_err_q,    o_err_d;

  logic gap_zero;
  logic at_last;
  logic frame_end;
  logic good_frame;
  logic bad_frame;
  logic pend_emit;
  logic direct_emit;
  logic overflow;

  // Frame boundary: either the producer says last, or the lane count runs out.
  assign at_last    = (idx_q == LAST_IDX);
  assign frame_end  = bus.i_valid && (bus.i_last || at_last);
  assign good_frame = bus.i_valid && bus.i_last && at_last;
  assign bad_frame  = frame_end && !good_frame;

  // A waiting frame always goes first; a fresh frame bypasses only an empty, idle path.
  assign pend_emit   = pend_vld_q && gap_zero;
  assign direct_emit = good_frame && gap_zero && !pend_vld_q;
  assign overflow    = good_frame && pend_vld_q && !pend_emit;

  // Next state for collection, pending buffer and output register.
  always_comb begin
    idx_d      = idx_q;
    collect_d  = collect_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    o_data_d   = o_data_q;
    o_valid_d  = 1'b0;
    o_err_d    = bad_frame || overflow;

    if (bus.i_valid) begin
      collect_d[lane_lo(int'(idx_q), inputWidth) +: inputWidth] = bus.i_data;
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end

    if (pend_emit) begin
      o_data_d   = pend_q;
      o_valid_d  = 1'b1;
      pend_vld_d = 1'b0;
    end else if (direct_emit) begin
      // collect_d already carries the final word of this frame.
      o_data_d  = collect_d;
      o_valid_d = 1'b1;
    end

    // Completed frame that cannot go out now parks in pending if pending is free
    // or being vacated this same cycle; otherwise it is the overflow case.
    if (good_frame && !direct_emit && (!pend_vld_q || pend_emit)) begin
      pend_d     = collect_d;
      pend_vld_d = 1'b1;
    end
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      collect_q  <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
      o_err_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      collect_q  <= collect_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      o_err_q    <= o_err_d;
    end
  end

  score_packer_gap_timer #(
    .WIDTH (GAP_W),
    .LOAD  (minGap - 1)
  ) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .load (o_valid_d),
    .zero (gap_zero)
  );

  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_busy  = pend_vld_q;
  assign bus.o_err   = o_err_q;
endmodule

// File: tb/tb_score_packer.sv
// Bench for score_packer: two instances (minGap 5 and 12) share one random/directed stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_score_packer;
  import score_packer_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    int          amax;
  } ev_t;

  typedef struct {
    int          cyc;
    bit          busy;
    logic [31:0] dat;
  } cyc_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] i_data = '0;
  logic         i_valid = 1'b0;
  logic         i_last = 1'b0;
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  score_packer_if #(.NUM_INPUT(N), .INPUT_WIDTH(W)) bus0 ();
  score_packer_if #(.NUM_INPUT(N), .INPUT_WIDTH(W)) bus1 ();

  assign bus0.i_data  = i_data;
  assign bus0.i_valid = i_valid;
  assign bus0.i_last  = i_last;
  assign bus1.i_data  = i_data;
  assign bus1.i_valid = i_valid;
  assign bus1.i_last  = i_last;

  score_packer #(.numInput(N), .inputWidth(W), .minGap(5)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  score_packer #(.numInput(N), .inputWidth(W), .minGap(12)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic        mv [2];
  logic        me [2];
  logic        mb [2];
  logic [31:0] md [2];
  assign mv[0] = bus0.o_valid;
  assign me[0] = bus0.o_err;
  assign mb[0] = bus0.o_busy;
  assign md[0] = bus0.o_data;
  assign mv[1] = bus1.o_valid;
  assign me[1] = bus1.o_err;
  assign mb[1] = bus1.o_busy;
  assign md[1] = bus1.o_data;

  // Reference model state: shared word collector plus per-instance emission state.
  logic [W-1:0] wq [$];
  bit           hp  [2];
  logic [31:0]  pd  [2];
  int           pam [2];
  logic [31:0]  cur [2];
  int           lv  [2];
  ev_t          qv  [2][$];
  int           qe  [2][$];
  cyc_t         qc  [2][$];

  function automatic int gap_of(input int m);
    return (m == 0) ? 5 : 12;
  endfunction

  // Argmax as the downstream stage sees it: first lane holding the largest score.
  function automatic int v_argmax(input logic [31:0] v);
    int best;
    best = 0;
    for (int k = 1; k < N; k++) begin
      if (v[lane_lo(k, W) +: W] > v[lane_lo(best, W) +: W]) best = k;
    end
    return best;
  endfunction

  function automatic int q_argmax();
    int best;
    best = 0;
    for (int k = 1; k < wq.size(); k++) begin
      if (wq[k] > wq[best]) best = k;
    end
    return best;
  endfunction

  task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d @cyc %0d: actual=%0h required=%0h", name, m, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    for (int m = 0; m < 2; m++) begin
      hp[m] = 1'b0;
      pd[m] = '0;
      pam[m] = 0;
      cur[m] = '0;
      lv[m] = -1000;
      qv[m].delete();
      qe[m].delete();
      qc[m].delete();
    end
  endtask

  task automatic emit(input int m, input int c, input logic [31:0] d, input int a);
    ev_t e;
    e.cyc = c;
    e.dat = d;
    e.amax = a;
    qv[m].push_back(e);
    cur[m] = d;
    lv[m] = c;
  endtask

  // One input cycle c: frames are judged by how many words have arrived; outputs
  // are due at c+1, and successive emissions must be at least minGap cycles apart.
  task automatic model_step(input bit v, input bit l, input logic [W-1:0] d);
    int          c;
    bit          good;
    bit          ferr;
    bit          can;
    bit          ov;
    logic [31:0] fd;
    int          fam;
    cyc_t        ce;
    c = cyc;
    good = 1'b0;
    ferr = 1'b0;
    fd = '0;
    fam = 0;
    if (v) begin
      wq.push_back(d);
      if (l || wq.size() == N) begin
        if (l && wq.size() == N) begin
          good = 1'b1;
          for (int k = 0; k < N; k++) fd[k*W +: W] = wq[k];
          fam = q_argmax();
        end else begin
          ferr = 1'b1;
        end
        wq.delete();
      end
    end
    for (int m = 0; m < 2; m++) begin
      can = ((c + 1 - lv[m]) >= gap_of(m));
      ov = 1'b0;
      if (hp[m] && can) begin
        emit(m, c + 1, pd[m], pam[m]);
        hp[m] = 1'b0;
        if (good) begin
          hp[m] = 1'b1;
          pd[m] = fd;
          pam[m] = fam;
        end
      end else if (good) begin
        if (!hp[m] && can) begin
          emit(m, c + 1, fd, fam);
        end else if (!hp[m]) begin
          hp[m] = 1'b1;
          pd[m] = fd;
          pam[m] = fam;
        end else begin
          ov = 1'b1;
        end
      end
      if (ferr || ov) qe[m].push_back(c + 1);
      ce.cyc = c + 1;
      ce.busy = hp[m];
      ce.dat = cur[m];
      qc[m].push_back(ce);
    end
  endtask

  task automatic drive(input bit v, input bit l, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    i_valid = v;
    i_last = l;
    i_data = d;
    model_step(v, l, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task automatic frame4(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
    drive(1'b1, 1'b0, a);
    drive(1'b1, 1'b0, b);
    drive(1'b1, 1'b0, c);
    drive(1'b1, 1'b1, d);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor: reset values while rst is high, otherwise per-cycle busy/data and
  // event-driven valid/err checks against the queued expectations.
  ev_t  mev;
  cyc_t mce;
  int   mcy;
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        chk("reset_outputs", m, {29'd0, mv[m], me[m], mb[m], md[m]}, 64'd0);
      end else begin
        if (qc[m].size() > 0 && qc[m][0].cyc == cyc) begin
          mce = qc[m].pop_front();
          chk("busy", m, mb[m], mce.busy);
          chk("data_hold", m, md[m], mce.dat);
        end
        while (qv[m].size() > 0 && qv[m][0].cyc < cyc) begin
          mev = qv[m].pop_front();
          tests++;
          fails++;
          $display("FAIL missing_valid dut%0d: actual=none required=valid@%0d", m, mev.cyc);
        end
        while (qe[m].size() > 0 && qe[m][0] < cyc) begin
          mcy = qe[m].pop_front();
          tests++;
          fails++;
          $display("FAIL missing_err dut%0d: actual=none required=err@%0d", m, mcy);
        end
        if (mv[m]) begin
          if (qv[m].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid dut%0d @cyc %0d: actual=valid required=none", m, cyc);
          end else begin
            mev = qv[m].pop_front();
            chk("valid_cycle", m, cyc, mev.cyc);
            chk("valid_data", m, md[m], mev.dat);
            chk("argmax", m, v_argmax(md[m]), mev.amax);
          end
        end
        if (me[m]) begin
          if (qe[m].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_err dut%0d @cyc %0d: actual=err required=none", m, cyc);
          end else begin
            mcy = qe[m].pop_front();
            chk("err_cycle", m, cyc, mcy);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    // Back-to-back frame.
    frame4(8'h11, 8'h22, 8'h33, 8'h44);
    idle(1);
    chk("s1_packed", 0, bus0.o_data, 64'h44332211);
    chk("s1_no_err", 0, bus0.o_err, 64'd0);
    idle(14);

    // Two frames at full rate.
    frame4(8'h01, 8'h02, 8'h03, 8'h04);
    frame4(8'h05, 8'h06, 8'h07, 8'h08);
    idle(20);

    // Short frame, then a good one.
    drive(1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b0, 8'hBB);
    drive(1'b1, 1'b1, 8'hCC);
    frame4(8'h01, 8'h02, 8'h03, 8'h04);
    idle(1);
    chk("s3_packed", 0, bus0.o_data, 64'h04030201);
    idle(14);

    // Three full-rate frames: the 12-cycle instance must drop the third.
    frame4(8'h10, 8'h90, 8'h30, 8'h40);
    frame4(8'h51, 8'h62, 8'hF3, 8'h04);
    frame4(8'h0A, 8'h0B, 8'h0C, 8'hFD);
    idle(30);

    // Idle cycles between words.
    drive(1'b1, 1'b0, 8'h11);
    idle(1);
    drive(1'b1, 1'b0, 8'h22);
    idle(1);
    drive(1'b1, 1'b0, 8'h33);
    idle(1);
    drive(1'b1, 1'b1, 8'h44);
    idle(1);
    chk("s5_packed", 0, bus0.o_data, 64'h44332211);
    idle(14);

    // Reset during a partial frame.
    drive(1'b1, 1'b0, 8'hE9);
    drive(1'b1, 1'b0, 8'hEA);
    async_reset();
    frame4(8'h05, 8'h06, 8'h07, 8'h08);
    idle(1);
    chk("s6_packed0", 0, bus0.o_data, 64'h08070605);
    chk("s6_packed1", 1, bus1.o_data, 64'h08070605);
    idle(14);

    // Random traffic with occasional framing errors.
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit l;
      v = (($urandom % 4) != 0);
      if (wq.size() == N - 1) l = (($urandom % 8) != 0);
      else l = (($urandom % 20) == 0);
      drive(v, l, W'($urandom));
    end
    idle(40);
    @(negedge clk);
    @(negedge clk);

    for (int m = 0; m < 2; m++) begin
      chk("leftover_valid", m, qv[m].size(), 64'd0);
      chk("leftover_err", m, qe[m].size(), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
